// File: rtl/fpmul_pkg.sv
// Shared types and constants for the shared FP multiplier front-end.
// Tag ids are ID_W wide, enough for up to 16 requesters.
package fpmul_pkg;

  localparam int DEF_EXP_LEN      = 8;
  localparam int DEF_MANTISSA_LEN = 23;
  localparam int DEF_MUL_LATENCY  = 5;
  localparam int BIAS = (1 << (DEF_EXP_LEN - 1)) - 1;
  localparam int ID_W = 4;

  function automatic int FP_W(input int exp_len, input int man_len);
    return exp_len + man_len + 1;
  endfunction

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } fp_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after the pointer.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IW-1:0]      o_grant_id
);

  logic [IW:0]   w_sum;
  logic [IW-1:0] w_idx;
  logic          w_found;

  always_comb begin
    o_grant    = '0;
    o_grant_id = '0;
    w_found    = 1'b0;
    w_sum      = '0;
    w_idx      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, i_ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(NUM_REQ))
        w_sum = w_sum - (IW+1)'(NUM_REQ);
      w_idx = w_sum[IW-1:0];
      if (!w_found && i_req[w_idx]) begin
        w_found         = 1'b1;
        o_grant[w_idx]  = 1'b1;
        o_grant_id      = w_idx;
      end
    end
  end

endmodule

// File: rtl/fpmul_share_arbiter.sv
// Shares one pipelined FP multiplier among NUM_REQ requesters.
// A tag pipe matched to the multiplier latency routes products back.
module fpmul_share_arbiter
  import fpmul_pkg::*;
#(
  parameter  int EXP_LEN         = DEF_EXP_LEN,
  parameter  int MANTISSA_LEN    = DEF_MANTISSA_LEN,
  parameter  int NUM_REQ         = 4,
  parameter  int MUL_LATENCY     = DEF_MUL_LATENCY,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int W = FP_W(EXP_LEN, MANTISSA_LEN)
) (
  input  logic                 clk,
  input  logic                 reset_neg,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*W-1:0] req_a,
  input  logic [NUM_REQ*W-1:0] req_b,
  output logic [W-1:0]         mul_a,
  output logic [W-1:0]         mul_b,
  input  logic [W-1:0]         mul_product,
  output logic [NUM_REQ-1:0]   resp_valid,
  output logic [W-1:0]         resp_product,
  output logic                 busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_O   = CW'(MAX_OUTSTANDING);
  localparam logic [IW-1:0] LAST_ID = IW'(NUM_REQ - 1);

  logic [IW-1:0]          r_ptr;
  fp_tag_t                r_tag [MUL_LATENCY];
  logic [CW-1:0]          r_outst [NUM_REQ];
  logic [NUM_REQ-1:0]     r_resp_valid;
  logic [W-1:0]           r_resp_product;

  logic [NUM_REQ-1:0]     w_elig;
  logic [NUM_REQ-1:0]     w_grant;
  logic [IW-1:0]          w_gid;
  logic [IW-1:0]          w_ret_id;
  logic                   w_xfer;
  logic                   w_ret;
  logic [MUL_LATENCY-1:0] w_tag_vld;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_elig
    assign w_elig[i] = req_valid[i] && (r_outst[i] < MAX_O);
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req      (w_elig),
    .i_ptr      (r_ptr),
    .o_grant    (w_grant),
    .o_grant_id (w_gid)
  );

  assign req_ready = reset_neg ? w_grant : '0;
  assign w_xfer    = |req_ready;
  assign mul_a     = w_xfer ? req_a[w_gid*W +: W] : '0;
  assign mul_b     = w_xfer ? req_b[w_gid*W +: W] : '0;

  always_ff @(posedge clk or negedge reset_neg) begin
    if (!reset_neg)
      r_ptr <= '0;
    else if (w_xfer)
      r_ptr <= (w_gid == LAST_ID) ? '0 : w_gid + 1'b1;
  end

  // The multiplier cannot stall, so the tag pipe shifts unconditionally.
  always_ff @(posedge clk or negedge reset_neg) begin
    if (!reset_neg) begin
      for (int k = 0; k < MUL_LATENCY; k++)
        r_tag[k] <= '0;
    end else begin
      r_tag[0] <= '{vld: w_xfer, id: ID_W'(w_gid)};
      for (int k = 1; k < MUL_LATENCY; k++)
        r_tag[k] <= r_tag[k-1];
    end
  end

  for (genvar k = 0; k < MUL_LATENCY; k++) begin : g_vld
    assign w_tag_vld[k] = r_tag[k].vld;
  end

  assign w_ret    = r_tag[MUL_LATENCY-1].vld;
  assign w_ret_id = r_tag[MUL_LATENCY-1].id[IW-1:0];

  always_ff @(posedge clk or negedge reset_neg) begin
    if (!reset_neg) begin
      r_resp_valid   <= '0;
      r_resp_product <= '0;
    end else begin
      r_resp_valid <= '0;
      if (w_ret) begin
        r_resp_valid[w_ret_id] <= 1'b1;
        r_resp_product         <= mul_product;
      end
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_outst
    logic w_inc;
    logic w_dec;
    assign w_inc = w_xfer && (w_gid == IW'(i));
    assign w_dec = w_ret && (w_ret_id == IW'(i));
    always_ff @(posedge clk or negedge reset_neg) begin
      if (!reset_neg) begin
        r_outst[i] <= '0;
      end else begin
        if (w_inc && !w_dec)
          r_outst[i] <= r_outst[i] + 1'b1;
        else if (w_dec && !w_inc)
          r_outst[i] <= r_outst[i] - 1'b1;
        assert (!(w_dec && !w_inc && r_outst[i] == '0));
        assert (!(w_inc && !w_dec && r_outst[i] == MAX_O));
      end
    end
  end

  assign resp_valid   = r_resp_valid;
  assign resp_product = r_resp_product;
  assign busy         = (|req_valid) || (|w_tag_vld);

endmodule

// File: tb/tb_fpmul_share_arbiter.sv
// Directed bench for fpmul_share_arbiter with a 5-stage multiplier stand-in.
// A negedge monitor scoreboards every transfer against its response.
module tb_fpmul_share_arbiter;
  import fpmul_pkg::*;

  localparam int LAT = 5;

  logic        clk;
  logic        reset_neg;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [31:0] mul_product;
  logic [3:0]  resp_valid;
  logic [31:0] resp_product;
  logic        busy;

  logic [31:0] A_TAB [4] = '{32'h3FC00000, 32'h40000000, 32'h40400000, 32'h3FC00000};
  logic [31:0] B_TAB [4] = '{32'h40000000, 32'h40000000, 32'h40000000, 32'h3FC00000};
  logic [31:0] P_TAB [4] = '{32'h40400000, 32'h40800000, 32'h40C00000, 32'h40100000};

  assign req_a = {A_TAB[3], A_TAB[2], A_TAB[1], A_TAB[0]};
  assign req_b = {B_TAB[3], B_TAB[2], B_TAB[1], B_TAB[0]};

  fpmul_share_arbiter #(
    .EXP_LEN(8), .MANTISSA_LEN(23), .NUM_REQ(4),
    .MUL_LATENCY(LAT), .MAX_OUTSTANDING(4)
  ) dut (
    .clk(clk), .reset_neg(reset_neg),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_product(mul_product),
    .resp_valid(resp_valid), .resp_product(resp_product),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] m;
    int e;
    if (a[30:0] == 0 || b[30:0] == 0) return {a[31] ^ b[31], 31'b0};
    m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - BIAS;
    if (m[47]) begin
      m = m >> 1;
      e = e + 1;
    end
    return {a[31] ^ b[31], e[7:0], m[45:23]};
  endfunction

  logic [31:0] r_mp [LAT];
  always @(posedge clk) begin
    r_mp[0] <= fmul(mul_a, mul_b);
    for (int k = 1; k < LAT; k++) r_mp[k] <= r_mp[k-1];
  end
  assign mul_product = r_mp[LAT-1];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct { int id; int cyc; } ent_t;
  ent_t q[$];
  int   cyc = 0;
  int   n_xfer = 0;
  int   n_resp = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    ent_t e;
    int   id;
    bit   bexp;
    if (!reset_neg) begin
      q.delete();
    end else if (mon_en) begin
      if (resp_valid != 0) begin
        n_resp++;
        if (q.size() == 0) begin
          chk("resp_unexp", 64'(resp_valid), 64'd0);
        end else begin
          e = q.pop_front();
          chk("resp_id", 64'(resp_valid), 64'(1 << e.id));
          chk("resp_prod", 64'(resp_product), 64'(P_TAB[e.id]));
          chk("resp_lat", 64'(cyc - e.cyc), 64'(LAT + 1));
        end
      end else if (q.size() != 0 && cyc - q[0].cyc > LAT + 1) begin
        chk("resp_miss", 64'(0), 64'(1));
        void'(q.pop_front());
      end
      bexp = (req_valid != 0);
      foreach (q[j]) if (cyc - q[j].cyc <= LAT) bexp = 1'b1;
      chk("busy", 64'(busy), 64'(bexp));
      if (req_ready != 0) begin
        id = 0;
        for (int i = 0; i < 4; i++) if (req_ready[i]) id = i;
        chk("rdy_1hot", 64'($onehot(req_ready)), 64'd1);
        chk("rdy_sub", 64'(req_ready & ~req_valid), 64'd0);
        chk("mul_a", 64'(mul_a), 64'(A_TAB[id]));
        chk("mul_b", 64'(mul_b), 64'(B_TAB[id]));
        n_xfer++;
        q.push_back('{id: id, cyc: cyc});
      end
    end
  end

  task automatic do_reset(input logic [3:0] v);
    @(posedge clk); #1;
    reset_neg = 1'b0;
    req_valid = v;
    @(posedge clk); #1;
    reset_neg = 1'b1;
  endtask

  task automatic drain(input int n);
    req_valid = 4'h0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic stall_test(input int id, input logic [11:0] pat);
    do_reset(4'h0);
    req_valid = 4'(1 << id);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_c%0d", id, k), 64'(req_ready), pat[k] ? 64'(1 << id) : 64'd0);
      @(posedge clk); #1;
    end
    drain(14);
  endtask

  initial begin
    int lat;
    int cnt;
    int x0;
    int r0;
    reset_neg = 1'b0;
    req_valid = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_mul_a", 64'(mul_a), 64'd0);
    chk("rst_mul_b", 64'(mul_b), 64'd0);
    chk("rst_resp_v", 64'(resp_valid), 64'd0);
    chk("rst_resp_p", 64'(resp_product), 64'd0);
    chk("rst_busy_v", 64'(busy), 64'd1);
    req_valid = 4'h0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    reset_neg = 1'b1;
    mon_en = 1'b1;

    // single op from requester 0
    @(posedge clk); #1;
    req_valid = 4'h1;
    @(negedge clk);
    chk("t1_ready", 64'(req_ready), 64'h1);
    chk("t1_mul_a", 64'(mul_a), 64'h3FC00000);
    chk("t1_mul_b", 64'(mul_b), 64'h40000000);
    @(posedge clk); #1;
    req_valid = 4'h0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (resp_valid != 0) begin
        lat = k;
        break;
      end
    end
    chk("t1_lat", 64'(lat), 64'd6);
    chk("t1_vld", 64'(resp_valid), 64'h1);
    chk("t1_prod", 64'(resp_product), 64'h40400000);
    drain(10);

    // all four valid from reset release
    do_reset(4'hF);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("t2_gnt%0d", k), 64'(req_ready), 64'(1 << (k % 4)));
      @(posedge clk); #1;
    end
    drain(12);

    // single requester saturates its outstanding limit
    stall_test(2, 12'h3CF);
    stall_test(1, 12'h3CF);

    // reset with three ops in flight
    do_reset(4'h0);
    req_valid = 4'h7;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("t5_gnt%0d", k), 64'(req_ready), 64'(1 << k));
      @(posedge clk); #1;
    end
    req_valid = 4'h0;
    @(posedge clk); #1;
    reset_neg = 1'b0;
    @(negedge clk);
    chk("t5_rst_resp", 64'(resp_valid), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    reset_neg = 1'b1;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (resp_valid != 0) cnt++;
    end
    chk("t5_noresp", 64'(cnt), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    req_valid = 4'hF;
    @(negedge clk);
    chk("t5_ptr0", 64'(req_ready), 64'h1);
    @(posedge clk); #1;
    drain(12);

    // random valids against the scoreboard
    x0 = n_xfer;
    r0 = n_resp;
    for (int k = 0; k < 10000; k++) begin
      req_valid = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
    end
    drain(14);
    chk("t6_drain", 64'(q.size()), 64'd0);
    chk("t6_count", 64'(n_resp - r0), 64'(n_xfer - x0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
